// File: rtl/alu_issue_pkg.sv
// Shared widths, opcodes and the EX-stage slot type for the two-stage ALU issue block.
package alu_issue_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    word_t             a;
    word_t             b;
  } ex_slot_t;

endpackage

// File: rtl/alu_issue_alu.sv
// Combinational ALU: AND / OR / XOR selected by control[1:0]; control[2] has no effect.
module alu
  import alu_issue_pkg::*;
(
  input  logic [2:0] control,
  input  word_t      A,
  input  word_t      B,
  output word_t      Out,
  output logic       Zero
);

  // operation select; both values of control[2] decode identically
  always_comb begin
    Out = {DATA_W{1'b0}};
    case (control)
      3'b000, 3'b100: Out = A & B;
      3'b001, 3'b101: Out = A | B;
      default:        Out = A ^ B;
    endcase
  end

  // zero detect on the selected result
  always_comb begin
    Zero = 1'b0;
    if (Out == {DATA_W{1'b0}}) begin
      Zero = 1'b1;
    end else begin
      Zero = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage (EX -> WB) ALU issue pipeline with an 8x16 register file, forwarding
// from the advancing EX result, and a direct register load port.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic [15:0]       retired
);

  ex_slot_t          ex_r;
  logic              ex_valid_r;
  logic              wb_valid_r;
  logic [REG_AW-1:0] wb_rd_r;
  word_t             wb_data_r;
  logic              zero_flag_r;
  logic [15:0]       retired_r;
  word_t             regs_r [NREG];

  word_t alu_out_s;
  logic  alu_zero_s;
  logic  ex_adv_s;
  logic  in_ready_s;
  logic  accept_s;
  word_t opa_s;
  word_t opb_s;

  alu u_alu (
    .control (ex_r.op),
    .A       (ex_r.a),
    .B       (ex_r.b),
    .Out     (alu_out_s),
    .Zero    (alu_zero_s)
  );

  // handshake: EX drains into WB when WB is empty or being consumed
  always_comb begin
    ex_adv_s   = 1'b0;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    ex_adv_s   = ex_valid_r & (~wb_valid_r | wb_ready);
    in_ready_s = rst_n & (~ex_valid_r | ex_adv_s) & ~ld_en;
    accept_s   = in_valid & in_ready_s;
  end

  // operand fetch, bypassing the register file when EX writes the same register this edge
  always_comb begin
    opa_s = regs_r[in_rs];
    opb_s = regs_r[in_rt];
    if (ex_adv_s && (ex_r.rd == in_rs)) begin
      opa_s = alu_out_s;
    end else begin
      opa_s = regs_r[in_rs];
    end
    if (ex_adv_s && (ex_r.rd == in_rt)) begin
      opb_s = alu_out_s;
    end else begin
      opb_s = regs_r[in_rt];
    end
  end

  // EX stage slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0;
      ex_r       <= '{op: 3'b000, rd: {REG_AW{1'b0}}, a: {DATA_W{1'b0}}, b: {DATA_W{1'b0}}};
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
      ex_r       <= '{op: in_op, rd: in_rd, a: opa_s, b: opb_s};
    end else if (ex_adv_s) begin
      ex_valid_r <= 1'b0;
    end
  end

  // WB stage, flags and retire counter; held stable while WB is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= {REG_AW{1'b0}};
      wb_data_r   <= {DATA_W{1'b0}};
      zero_flag_r <= 1'b0;
      retired_r   <= 16'h0000;
    end else if (ex_adv_s) begin
      wb_valid_r  <= 1'b1;
      wb_rd_r     <= ex_r.rd;
      wb_data_r   <= alu_out_s;
      zero_flag_r <= alu_zero_s;
      retired_r   <= retired_r + 16'd1;
    end else if (wb_ready) begin
      wb_valid_r  <= 1'b0;
    end
  end

  // register file; the EX writeback is ordered after the load so it wins on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (ld_en) begin
        regs_r[ld_addr] <= ld_data;
      end
      if (ex_adv_s) begin
        regs_r[ex_r.rd] <= alu_out_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign wb_valid  = wb_valid_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;
  assign zero_flag = zero_flag_r;
  assign retired   = retired_r;

endmodule

// File: tb/tb_alu_issue.sv
// Directed, table-driven bench for alu_issue with hand-computed expectations
// plus hand-written sequences for forwarding, backpressure, collisions and reset.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op, in_rd, in_rs, in_rt;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        zero_flag;
  logic [15:0] retired;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_ret;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] data;
    logic        zero;
  } vec_t;

  vec_t vecs [7];

  alu_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .zero_flag (zero_flag),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
  endtask

  // single instruction with WB free: result must be presented one edge after acceptance
  task automatic issue_one(input string name, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt,
                           input logic [15:0] exp_data, input logic exp_zero);
    set_instr(op, rd, rs, rt);
    #1 chk({name, " in_ready"}, {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    tick();
    exp_ret = exp_ret + 16'd1;
    chk({name, " wb_valid"}, {15'd0, wb_valid}, 16'd1);
    chk({name, " wb_data"}, wb_data, exp_data);
    chk({name, " wb_rd"}, {13'd0, wb_rd}, {13'd0, rd});
    chk({name, " zero_flag"}, {15'd0, zero_flag}, {15'd0, exp_zero});
    chk({name, " retired"}, retired, exp_ret);
  endtask

  initial begin
    in_valid = 1'b0; in_op = 3'd0; in_rd = 3'd0; in_rs = 3'd0; in_rt = 3'd0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0000; wb_ready = 1'b1;
    exp_ret = 16'd0;

    vecs[0] = '{OP_AND, 3'd3, 3'd1, 3'd2, 16'h00F0, 1'b0};
    vecs[1] = '{OP_XOR, 3'd4, 3'd1, 3'd1, 16'h0000, 1'b1};
    vecs[2] = '{OP_AND, 3'd5, 3'd4, 3'd2, 16'h0000, 1'b1};
    vecs[3] = '{OP_OR,  3'd6, 3'd1, 3'd2, 16'h0FF0, 1'b0};
    vecs[4] = '{3'b110, 3'd0, 3'd6, 3'd1, 16'h0F00, 1'b0};
    vecs[5] = '{3'b101, 3'd7, 3'd0, 3'd3, 16'h0FF0, 1'b0};
    vecs[6] = '{OP_OR,  3'd3, 3'd3, 3'd3, 16'h00F0, 1'b0};

    // asynchronous reset, checked before any clock edge
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("rst wb_data", wb_data, 16'h0000);
    chk("rst wb_rd", {13'd0, wb_rd}, 16'd0);
    chk("rst zero_flag", {15'd0, zero_flag}, 16'd0);
    chk("rst retired", retired, 16'h0000);
    chk("rst in_ready", {15'd0, in_ready}, 16'd0);
    #11 rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", {15'd0, in_ready}, 16'd1);

    load(3'd1, 16'h00F0);
    load(3'd2, 16'h0FF0);
    chk("load wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("load retired", retired, 16'h0000);

    for (int i = 0; i < 7; i++) begin
      issue_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                vecs[i].data, vecs[i].zero);
    end

    // a load must not disturb a stalled WB or the counters
    wb_ready = 1'b0;
    load(3'd7, 16'hBEEF);
    chk("ld-hold wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("ld-hold wb_data", wb_data, 16'h00F0);
    chk("ld-hold wb_rd", {13'd0, wb_rd}, 16'd3);
    chk("ld-hold zero_flag", {15'd0, zero_flag}, 16'd0);
    chk("ld-hold retired", retired, exp_ret);
    wb_ready = 1'b1;
    tick();
    chk("consume wb_valid", {15'd0, wb_valid}, 16'd0);

    // back-to-back dependency through forwarding
    set_instr(OP_OR, 3'd6, 3'd1, 3'd2);
    tick();
    set_instr(OP_XOR, 3'd7, 3'd6, 3'd2);
    #1 chk("b2b in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    exp_ret = exp_ret + 16'd1;
    chk("b2b first data", wb_data, 16'h0FF0);
    chk("b2b first rd", {13'd0, wb_rd}, 16'd6);
    chk("b2b first retired", retired, exp_ret);
    tick();
    exp_ret = exp_ret + 16'd1;
    chk("b2b second data", wb_data, 16'h0000);
    chk("b2b second rd", {13'd0, wb_rd}, 16'd7);
    chk("b2b second zero", {15'd0, zero_flag}, 16'd1);
    chk("b2b second retired", retired, exp_ret);
    tick();
    chk("b2b drained", {15'd0, wb_valid}, 16'd0);

    // backpressure: four edges with wb_ready low, three instructions offered
    wb_ready = 1'b0;
    set_instr(OP_OR, 3'd3, 3'd1, 3'd1);
    tick();
    set_instr(OP_XOR, 3'd4, 3'd2, 3'd1);
    tick();
    exp_ret = exp_ret + 16'd1;
    set_instr(OP_AND, 3'd5, 3'd2, 3'd2);
    #1 chk("bp in_ready low", {15'd0, in_ready}, 16'd0);
    tick();
    chk("bp hold data e3", wb_data, 16'h00F0);
    tick();
    chk("bp hold valid", {15'd0, wb_valid}, 16'd1);
    chk("bp hold data", wb_data, 16'h00F0);
    chk("bp hold rd", {13'd0, wb_rd}, 16'd3);
    chk("bp hold in_ready", {15'd0, in_ready}, 16'd0);
    chk("bp hold retired", retired, exp_ret);
    wb_ready = 1'b1;
    #1 chk("bp release in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    exp_ret = exp_ret + 16'd1;
    chk("bp second data", wb_data, 16'h0F00);
    chk("bp second rd", {13'd0, wb_rd}, 16'd4);
    chk("bp second retired", retired, exp_ret);
    tick();
    exp_ret = exp_ret + 16'd1;
    chk("bp third data", wb_data, 16'h0FF0);
    chk("bp third rd", {13'd0, wb_rd}, 16'd5);
    chk("bp third retired", retired, exp_ret);
    tick();
    chk("bp drained", {15'd0, wb_valid}, 16'd0);

    // load and writeback to the same register on one edge: writeback wins
    load(3'd0, 16'h1234);
    set_instr(OP_OR, 3'd3, 3'd0, 3'd0);
    tick();
    in_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hAAAA;
    tick();
    ld_en = 1'b0;
    exp_ret = exp_ret + 16'd1;
    chk("collide wb_data", wb_data, 16'h1234);
    issue_one("collide probe r3", OP_OR, 3'd3, 3'd3, 3'd3, 16'h1234, 1'b0);

    // load and writeback to different registers on one edge: both land
    set_instr(OP_OR, 3'd4, 3'd1, 3'd1);
    tick();
    in_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h3C3C;
    tick();
    ld_en = 1'b0;
    exp_ret = exp_ret + 16'd1;
    issue_one("split probe r4", OP_OR, 3'd4, 3'd4, 3'd4, 16'h00F0, 1'b0);
    issue_one("split probe r6", OP_OR, 3'd6, 3'd6, 3'd6, 16'h3C3C, 1'b0);

    // reset with both EX and WB occupied
    wb_ready = 1'b0;
    set_instr(OP_AND, 3'd1, 3'd2, 3'd2);
    tick();
    set_instr(OP_XOR, 3'd2, 3'd2, 3'd2);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("midrst retired", retired, 16'h0000);
    chk("midrst wb_data", wb_data, 16'h0000);
    chk("midrst wb_rd", {13'd0, wb_rd}, 16'd0);
    chk("midrst zero_flag", {15'd0, zero_flag}, 16'd0);
    chk("midrst in_ready", {15'd0, in_ready}, 16'd0);
    #2 rst_n = 1'b1;
    wb_ready = 1'b1;
    tick();
    exp_ret = 16'd0;
    for (int k = 0; k < 8; k++) begin
      issue_one($sformatf("midrst probe r%0d", k), OP_OR, k[2:0], k[2:0], k[2:0], 16'h0000, 1'b1);
    end

    // full-rate stream long enough to wrap the retire counter
    set_instr(OP_OR, 3'd0, 3'd0, 3'd0);
    repeat (65530) tick();
    in_valid = 1'b0;
    tick();
    exp_ret = exp_ret + 16'd65530;
    chk("stream wrap retired", retired, exp_ret);
    chk("stream zero_flag", {15'd0, zero_flag}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
